layer_act_buffer: RTL

Ping-pong activation buffer that sits directly upstream of a layer's node array. It accepts a serial stream of IEEE-754 single-precision activations from the previous layer, one word per handshake. It assembles frames of N words and presents each completed frame as a stable, flattened parallel bus to the combinational multiply/add/ReLU nodes. Two banks let the next frame load while the current frame is held for the node array to settle and be captured.

---
 rtl/layer_act_buffer.sv | 114 +++++++++++
 1 files changed

// File: rtl/layer_act_buffer.sv
// layer_act_buffer
// Ping-pong activation buffer feeding a layer's combinational node array.
// Serial float32 words arrive one per handshake. Every N words are assembled
// into one of two banks, and each completed frame is held on a flat parallel
// bus until the consumer acknowledges it. While one bank is held, the other
// bank can load the next frame.
//
// Ports
//   clk, rst_n         : clock; asynchronous active-low reset
//   in_data/in_valid   : incoming activation word
//   in_last            : final word of a frame (qualified by in_valid)
//   in_ready           : a word can be accepted this cycle
//   a_flat             : frame bus; word k sits at [k*W +: W]; zero when not valid
//   out_valid          : a_flat holds a complete frame
//   out_ack            : consumer is done with the frame and releases it
//   frame_err          : one-cycle pulse when a malformed frame is discarded
//   frame_cnt          : number of frames released (wraps at 2^16)
module layer_act_buffer #(
    parameter int N = 30,
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [W-1:0]   in_data,
    input  logic           in_valid,
    input  logic           in_last,
    output logic           in_ready,
    output logic [N*W-1:0] a_flat,
    output logic           out_valid,
    input  logic           out_ack,
    output logic           frame_err,
    output logic [15:0]    frame_cnt
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [1:0][N-1:0][W-1:0] bank;
    logic [1:0]               full, full_nxt;
    logic                     wr_bank, rd_bank;
    logic [IW-1:0]            wr_idx;
    logic                     dropping;   // discarding the tail of a long frame
    logic                     acc, wr_en, rel, at_end, set_full, err_now;

    // A dropping writer always targets a non-full bank, so ready is held high
    // until the tail of the long frame has been consumed.
    assign in_ready  = dropping | ~full[wr_bank];
    assign acc       = in_valid & in_ready;
    assign wr_en     = acc & ~dropping;
    assign at_end    = (wr_idx == IW'(N - 1));
    assign rel       = out_ack & full[rd_bank];
    assign out_valid = full[rd_bank];
    // Gate the bus so the downstream ReLU nodes see a defined 0 between frames.
    assign a_flat    = out_valid ? bank[rd_bank] : '0;

    always_comb begin
        set_full = 1'b0;
        err_now  = 1'b0;
        if (wr_en) begin
            if (in_last) begin
                if (at_end) set_full = 1'b1;
                else        err_now  = 1'b1;   // short frame
            end else if (at_end) begin
                err_now = 1'b1;                // long frame
            end
        end
        // Completion and release always target different banks, so both apply.
        full_nxt = full;
        if (set_full) full_nxt[wr_bank] = 1'b1;
        if (rel)      full_nxt[rd_bank] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank <= '0;
        end else if (wr_en) begin
            for (int b = 0; b < 2; b++)
                for (int k = 0; k < N; k++)
                    if (wr_bank == 1'(b) && wr_idx == IW'(k))
                        bank[b][k] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            dropping  <= 1'b0;
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            full      <= full_nxt;
            frame_err <= err_now;
            if (acc) begin
                if (dropping) begin
                    if (in_last) dropping <= 1'b0;
                end else if (in_last) begin
                    // Good end or short frame: either way restart the bank.
                    wr_idx <= '0;
                    if (set_full) wr_bank <= ~wr_bank;
                end else if (at_end) begin
                    wr_idx   <= '0;
                    dropping <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + IW'(1);
                end
            end
            if (rel) begin
                rd_bank   <= ~rd_bank;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
endmodule
